// File: rtl/fa_pkg.sv
// Shared constants for the ripple-carry adder: operand width default/limits and reset value.
// Pure declarations: no logic, no latency, no backpressure.
package fa_pkg;

  localparam int FA_WIDTH_DEFAULT = 1;
  localparam int FA_WIDTH_MIN     = 1;
  localparam int FA_WIDTH_MAX     = 64;

  // Wide enough for the largest legal WIDTH; users slice the low bits they need.
  localparam logic [FA_WIDTH_MAX-1:0] FA_RST_VAL = '0;

endpackage : fa_pkg

// File: rtl/full_adder_cell.sv
// One-bit full adder cell: s = a^b^cin, cout = ab | cin(a^b).
// Purely combinational, zero latency, no backpressure.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p_w;

  assign p_w  = a ^ b;
  assign s    = p_w ^ cin;
  assign cout = (a & b) | (cin & p_w);

endmodule : full_adder_cell

// File: rtl/full_adder_dataflow.sv
// WIDTH-bit ripple-carry adder ({cout,s} = a+b+cin) with a sticky carry_seen flag; no backpressure.
// Sum/carry are combinational by default; defining FA_OUTPUT_REG_EN registers them (1-cycle latency).
module full_adder_dataflow
  import fa_pkg::*;
#(
  parameter int WIDTH = FA_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             carry_seen
);

  logic [WIDTH:0]   carry_w;
  logic [WIDTH-1:0] sum_w;
  logic             flag_src_w;
  logic             carry_seen_q;
  logic             carry_seen_d;

  assign carry_w[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry_w[i]),
      .s    (sum_w[i]),
      .cout (carry_w[i+1])
    );
  end

`ifdef FA_OUTPUT_REG_EN
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] s_d;
  logic             cout_q;
  logic             cout_d;

  assign s_d    = sum_w;
  assign cout_d = carry_w[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q    <= FA_RST_VAL[WIDTH-1:0];
      cout_q <= FA_RST_VAL[0];
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  // The flag follows the visible carry, so it trails the registered cout by one cycle.
  assign flag_src_w = cout_q;
`else
  assign s          = sum_w;
  assign cout       = carry_w[WIDTH];
  assign flag_src_w = carry_w[WIDTH];
`endif

  assign carry_seen_d = carry_seen_q | flag_src_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_seen_q <= FA_RST_VAL[0];
    end else begin
      carry_seen_q <= carry_seen_d;
    end
  end

  assign carry_seen = carry_seen_q;

endmodule : full_adder_dataflow

// File: tb/tb_full_adder_dataflow.sv
// Directed and random checks of full_adder_dataflow at WIDTH 1, 8 and 16.
// Expectations adapt to whether FA_OUTPUT_REG_EN is defined.
module tb_full_adder_dataflow;

  typedef struct {
    logic a;
    logic b;
    logic cin;
    logic s;
    logic cout;
  } vec1_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       cout;
  } vec8_t;

  logic        clk;
  logic        rst;
  logic        a1, b1, cin1;
  logic        s1, cout1, seen1;
  logic [7:0]  a8, b8, s8;
  logic        cin8, cout8, seen8;
  logic [15:0] a16, b16, s16;
  logic        cin16, cout16, seen16;

  int total;
  int bad;

  vec1_t tv1[8];
  vec8_t tv8[5];

  full_adder_dataflow #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1),
    .s(s1), .cout(cout1), .carry_seen(seen1)
  );

  full_adder_dataflow #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
    .s(s8), .cout(cout8), .carry_seen(seen8)
  );

  full_adder_dataflow #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .a(a16), .b(b16), .cin(cin16),
    .s(s16), .cout(cout16), .carry_seen(seen16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Wait until results of the inputs just applied are visible.
  task automatic settle();
`ifdef FA_OUTPUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    tv1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tv1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tv1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tv1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tv1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tv1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tv1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    tv8[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tv8[1] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
    tv8[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tv8[3] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    tv8[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

    rst = 1'b1;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    a8 = '0;   b8 = '0;   cin8 = 1'b0;
    a16 = '0;  b16 = '0;  cin16 = 1'b0;
    #1;
    check("reset_seen_w1", 64'(seen1), 64'd0);
    check("reset_seen_w8", 64'(seen8), 64'd0);
    check("reset_seen_w16", 64'(seen16), 64'd0);
`ifdef FA_OUTPUT_REG_EN
    check("reset_s_w1", 64'(s1), 64'd0);
    check("reset_cout_w1", 64'(cout1), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Full truth table at one vector per clock period.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a1 = tv1[i].a; b1 = tv1[i].b; cin1 = tv1[i].cin;
      settle();
      check($sformatf("tt%0d_s", i), 64'(s1), 64'(tv1[i].s));
      check($sformatf("tt%0d_cout", i), 64'(cout1), 64'(tv1[i].cout));
    end

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a8 = tv8[i].a; b8 = tv8[i].b; cin8 = tv8[i].cin;
      settle();
      check($sformatf("w8_%0d_s", i), 64'(s8), 64'(tv8[i].s));
      check($sformatf("w8_%0d_cout", i), 64'(cout8), 64'(tv8[i].cout));
    end

    // Sticky flag: no carry for three edges, then a single carrying cycle.
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    pulse_reset();
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sticky_no_carry", 64'(seen1), 64'd0);
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    @(posedge clk);
    #1;
`ifdef FA_OUTPUT_REG_EN
    check("sticky_lags_reg", 64'(seen1), 64'd0);
`else
    check("sticky_set_same_edge", 64'(seen1), 64'd1);
`endif
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("sticky_hold", 64'(seen1), 64'd1);

    // Reset between edges clears the flag at once and blocks it while held.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midop_rst_clear", 64'(seen1), 64'd0);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_seen", 64'(seen1), 64'd0);
`ifdef FA_OUTPUT_REG_EN
    check("rst_held_s", 64'(s1), 64'd0);
    check("rst_held_cout", 64'(cout1), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;

`ifdef FA_OUTPUT_REG_EN
    // Output register: old values hold until the sampling edge.
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
    #1;
    check("reg_prev_s", 64'(s1), 64'd1);
    check("reg_prev_cout", 64'(cout1), 64'd0);
    @(posedge clk);
    #1;
    check("reg_new_s", 64'(s1), 64'd0);
    check("reg_new_cout", 64'(cout1), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("reg_rst_s", 64'(s1), 64'd0);
    check("reg_rst_cout", 64'(cout1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b0;
`endif

    // Random 16-bit sweep against a+b+cin.
    begin
      int          sweep_bad;
      logic [16:0] exp17;
      sweep_bad = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        a16   = 16'($urandom);
        b16   = 16'($urandom);
        cin16 = 1'($urandom);
        exp17 = {1'b0, a16} + {1'b0, b16} + 17'(cin16);
        settle();
        if ({cout16, s16} !== exp17) begin
          sweep_bad++;
          if (sweep_bad <= 5)
            check($sformatf("rand16_%0d", i), 64'({cout16, s16}), 64'(exp17));
        end else if (i % 100 == 0) begin
          check($sformatf("rand16_%0d", i), 64'({cout16, s16}), 64'(exp17));
        end
      end
      check("rand16_errors", 64'(sweep_bad), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_full_adder_dataflow

// File: doc/full_adder_dataflow.md
FULL_ADDER_DATAFLOW -- requirements
Module: full_adder_dataflow

Interface
REQ-001 The block SHALL have parameter WIDTH, default 1, setting the operand width in bits; legal range 1..64.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all registers update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-004 The block SHALL have port a, input, WIDTH bits, the first addend.
REQ-005 The block SHALL have port b, input, WIDTH bits, the second addend.
REQ-006 The block SHALL have port cin, input, 1 bit, the carry-in.
REQ-007 The block SHALL have port s, output, WIDTH bits, the sum.
REQ-008 The block SHALL have port cout, output, 1 bit, the carry-out.
REQ-009 The block SHALL have port carry_seen, output, 1 bit, a sticky flag that cout has been 1.

Function
REQ-010 The block SHALL compute {cout, s} = a + b + cin as an unsigned (WIDTH+1)-bit result; no overflow is lost.
REQ-011 Each bit i SHALL satisfy s[i] = a[i] XOR b[i] XOR c[i] and c[i+1] = a[i]b[i] OR c[i](a[i] XOR b[i]), with c[0] = cin and cout = c[WIDTH].
REQ-012 For WIDTH=1 the truth table SHALL be: 000->s0 c0, 001->s1 c0, 010->s1 c0, 011->s0 c1, 100->s1 c0, 101->s0 c1, 110->s0 c1, 111->s1 c1 (inputs a,b,cin).
REQ-013 In the default (combinational) build, s and cout SHALL follow the inputs with zero clock latency and no dependence on clk or rst.
REQ-014 carry_seen SHALL be a register that sets to 1 on any rising clk edge where the internal cout is 1, and holds 1 until reset.
REQ-015 When the inputs change between clock edges, only the value present at the rising edge SHALL affect registered state.
REQ-016 Inputs containing X or Z are out of scope; the outputs are not specified for them.

Reset
REQ-017 Assertion of rst SHALL immediately clear carry_seen to 0, and clear s and cout to 0 when FA_OUTPUT_REG_EN is defined, without waiting for a clock edge.
REQ-018 While rst is high, the registered outputs SHALL hold 0 and carry_seen SHALL NOT set.
REQ-019 On the first rising clk edge after rst deasserts, normal operation SHALL resume.
REQ-020 If reset is asserted mid-operation, any pending registered result SHALL be discarded.

Configuration
REQ-021 When macro FA_OUTPUT_REG_EN is defined, s and cout SHALL be registered with exactly 1-cycle latency: the values at edge n reflect the inputs sampled at edge n.
REQ-022 In that build, carry_seen SHALL set from the registered cout, so it rises one cycle after the carry appears.
REQ-023 When FA_OUTPUT_REG_EN is not defined, the behaviour of REQ-013 SHALL apply and the port list SHALL be unchanged.

Structure
REQ-024 A shared package fa_pkg SHALL hold the WIDTH default, the WIDTH range limits, and the reset value constant (all zeros).
REQ-025 The single-bit logic SHALL be a sub-module full_adder_cell (a, b, cin -> s, cout), instantiated WIDTH times in a ripple chain using a generate loop.
REQ-026 The datapath SHALL be written as continuous dataflow assignments; the only procedural logic SHALL be the reset/clock registers.

Verification
REQ-027 WIDTH=1, combinational build: all 8 input combinations applied at 10 ns spacing -> s/cout match REQ-012 within the same time step.
REQ-028 WIDTH=8: a=0xFF, b=0x01, cin=0 -> s=0x00, cout=1; then a=0x7F, b=0x80, cin=1 -> s=0x00, cout=1.
REQ-029 Reset mid-operation: carry_seen=1, assert rst between clock edges -> carry_seen=0 immediately; it stays 0 while rst=1 even with a=b=cin=1.
REQ-030 FA_OUTPUT_REG_EN, WIDTH=1: a=1, b=1, cin=0 sampled at edge n -> s=0, cout=1 visible after edge n, and previous values before it; after rst, s=0 and cout=0.
REQ-031 Sticky flag: 1+0+0 for 3 cycles -> carry_seen=0; one cycle of 1+1+1 -> carry_seen=1, which remains 1 after the inputs return to 0.
REQ-032 Random WIDTH=16 sweep of 1000 vectors -> {cout, s} equals the golden a+b+cin on every vector.
